id_decode_stage: RTL and testbench
==================================

// Module: id_decode_stage
// PURPOSE
//  Decode stage of the rv32i pipeline. Sits between the IF/ID register and EX.
//  Decodes the incoming instruction into an rv32i_control_word, detects load-use hazards
//  against the instruction held in ID/EX, and owns the ID/EX pipeline register
//  (stall, flush, bubble insertion). Also counts inserted bubbles for performance tracking.
// PARAMETERS
//  CNT_W      16  width of the saturating bubble counter
//  EN_HAZARD  1   1: load-use detection enabled; 0: never insert bubbles
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  if_valid     in   1      if_instr/if_pc hold a valid instruction
//  if_instr     in   32     instruction from IF/ID
//  if_pc        in   32     PC of if_instr
//  ex_stall     in   1      EX cannot accept; hold ID/EX contents
//  flush        in   1      squash ID/EX (taken branch/jump resolved in EX)
//  id_ready     out  1      ID consumes if_instr this cycle; IF must hold when 0
//  ex_valid     out  1      ID/EX entry valid
//  ex_ctrl      out  $bits(rv32i_control_word)  registered control word
//  ex_pc        out  32     registered PC
//  ex_rs1       out  5      registered instr[19:15]
//  ex_rs2       out  5      registered instr[24:20]
//  ex_illegal   out  1      registered: opcode not in {lui..op_reg}, or op_csr
//  bubble_cnt   out  CNT_W  saturating count of load-use bubbles inserted
// BEHAVIOUR
//  Decode (combinational; defaults: aluop=alu_add, cmpop=beq, regfilemux=alu_out,
//  pcmux=pc_plus4, rd=instr[11:7], u_imm={instr[31:12],12'h0}, load_regfile/read/write=0):
//   lui: load_regfile, regfilemux=u_imm.  auipc: load_regfile.
//   jal: load_regfile, regfilemux=pc_plus4, pcmux=alu_out.
//   jalr: load_regfile, regfilemux=pc_plus4, pcmux=alu_mod2.
//   br: cmpop=funct3.  store: write.
//   load: read, load_regfile, regfilemux=lb/lh/lw/lbu/lhu from funct3; other funct3 -> illegal.
//   op_imm/op_reg: load_regfile; aluop from funct3 (add,sll,xor,or,and direct);
//    sr: instr[30] ? alu_sra : alu_srl; op_reg add: instr[30] ? alu_sub : alu_add;
//    slt/sltu: cmpop=blt/bltu, regfilemux=br_en.
//   op_csr/unknown: all controls default, load_regfile/read/write=0, ex_illegal=1.
//  Hazard: haz = EN_HAZARD & if_valid & ex_valid & ex_ctrl.read & ex_ctrl.rd!=0 &
//   ((uses_rs1 & rs1==ex_ctrl.rd) | (uses_rs2 & rs2==ex_ctrl.rd));
//   uses_rs1: jalr,br,load,store,op_imm,op_reg; uses_rs2: br,store,op_reg.
//  id_ready = ~ex_stall & ~haz & ~flush  (combinational).
//  ID/EX update, priority order, each rising edge:
//   rst   -> ex_valid=0, ex_ctrl=0, ex_pc=0, ex_rs1/rs2=0, ex_illegal=0, bubble_cnt=0
//   flush -> ex_valid=0, ex_illegal=0 (flush beats stall; IF squashes its own entry)
//   ex_stall -> all ID/EX regs hold
//   haz   -> ex_valid=0, ex_ctrl.load_regfile/read/write=0 (bubble);
//            bubble_cnt+=1, saturating at all-ones
//   if_valid -> load decoded fields, ex_valid=1
//   else  -> ex_valid=0, ex_ctrl.load_regfile/read/write=0
//  Latency: 1 cycle from if_valid&id_ready to ex_valid. A load-use pair costs exactly 1 bubble;
//   on the next cycle ex_ctrl.read is 0 for the bubble, so haz clears.
//  Invalid entries never carry load_regfile/read/write=1.
//  Reset mid-stall/mid-hazard: rst wins; no partial state survives.
// TESTING
//  addi x1,x2,5 (0x00510093), if_valid=1 -> next cycle ex_valid=1, opcode=op_imm,
//   aluop=alu_add, rd=1, load_regfile=1, ex_rs1=2, ex_pc=if_pc.
//  lw x3,0(x1) (0x0000A183), then add x4,x3,x5 (0x00518233) -> one cycle id_ready=0,
//   ex_valid=0, bubble_cnt=1; then add enters with aluop=alu_add.
//  sub x6,x7,x8 (0x40838333) -> alu_sub; srai x1,x1,3 (0x4030D093) -> alu_sra;
//   lui x5,0x12345 (0x123452B7) -> u_imm=0x12345000, regfilemux=u_imm.
//  ex_stall=1 for 3 cycles with if_valid=1 -> ID/EX unchanged, id_ready=0;
//   flush with ex_stall=1 -> ex_valid=0 next cycle.
//  op_csr (0x00000073) -> ex_illegal=1, load_regfile=read=write=0; CNT_W=2 and
//   4 load-use pairs -> bubble_cnt saturates at 3; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_decode_stage.sv
// rv32i decode stage: instruction decode, load-use hazard detection and the ID/EX register.
// Also keeps a saturating count of inserted load-use bubbles.
package rv32i_types;
  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100, bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [3:0] {
    rf_alu_out = 4'd0, rf_br_en = 4'd1, rf_u_imm = 4'd2, rf_lw  = 4'd3, rf_pc_plus4 = 4'd4,
    rf_lb      = 4'd5, rf_lbu   = 4'd6, rf_lh    = 4'd7, rf_lhu = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [1:0] {
    pc_plus4 = 2'd0, pc_alu_out = 2'd1, pc_alu_mod2 = 2'd2
  } pcmux_sel_t;

  typedef struct packed {
    rv32i_opcode     opcode;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    regfilemux_sel_t regfilemux;
    pcmux_sel_t      pcmux;
    logic            load_regfile;
    logic            read;
    logic            write;
    logic [4:0]      rd;
    logic [31:0]     u_imm;
  } rv32i_control_word;
endpackage

module id_decode_stage
  import rv32i_types::*;
#(
  parameter int CNT_W     = 16,
  parameter bit EN_HAZARD = 1'b1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                if_valid,
  input  logic [31:0]                         if_instr,
  input  logic [31:0]                         if_pc,
  input  logic                                ex_stall,
  input  logic                                flush,
  output logic                                id_ready,
  output logic                                ex_valid,
  output logic [$bits(rv32i_control_word)-1:0] ex_ctrl,
  output logic [31:0]                         ex_pc,
  output logic [4:0]                          ex_rs1,
  output logic [4:0]                          ex_rs2,
  output logic                                ex_illegal,
  output logic [CNT_W-1:0]                    bubble_cnt
);

  rv32i_control_word dec, ex_ctrl_q;
  logic dec_illegal, uses_rs1, uses_rs2, haz;
  logic [2:0] funct3;

  assign funct3  = if_instr[14:12];
  assign ex_ctrl = ex_ctrl_q;

  always_comb begin
    dec              = '0;
    dec.opcode       = rv32i_opcode'(if_instr[6:0]);
    dec.aluop        = alu_add;
    dec.cmpop        = beq;
    dec.regfilemux   = rf_alu_out;
    dec.pcmux        = pc_plus4;
    dec.rd           = if_instr[11:7];
    dec.u_imm        = {if_instr[31:12], 12'h000};
    dec_illegal      = 1'b0;
    uses_rs1         = 1'b0;
    uses_rs2         = 1'b0;
    case (if_instr[6:0])
      op_lui: begin
        dec.load_regfile = 1'b1;
        dec.regfilemux   = rf_u_imm;
      end
      op_auipc: dec.load_regfile = 1'b1;
      op_jal: begin
        dec.load_regfile = 1'b1;
        dec.regfilemux   = rf_pc_plus4;
        dec.pcmux        = pc_alu_out;
      end
      op_jalr: begin
        dec.load_regfile = 1'b1;
        dec.regfilemux   = rf_pc_plus4;
        dec.pcmux        = pc_alu_mod2;
        uses_rs1         = 1'b1;
      end
      op_br: begin
        dec.cmpop = branch_funct3_t'(funct3);
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      op_store: begin
        dec.write = 1'b1;
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      op_load: begin
        uses_rs1         = 1'b1;
        dec.read         = 1'b1;
        dec.load_regfile = 1'b1;
        case (funct3)
          3'b000:  dec.regfilemux = rf_lb;
          3'b001:  dec.regfilemux = rf_lh;
          3'b010:  dec.regfilemux = rf_lw;
          3'b100:  dec.regfilemux = rf_lbu;
          3'b101:  dec.regfilemux = rf_lhu;
          default: begin
            // undefined load width: keep the entry inert
            dec.read         = 1'b0;
            dec.load_regfile = 1'b0;
            dec_illegal      = 1'b1;
          end
        endcase
      end
      op_imm, op_reg: begin
        dec.load_regfile = 1'b1;
        uses_rs1         = 1'b1;
        uses_rs2         = (if_instr[6:0] == op_reg);
        case (funct3)
          3'b000: dec.aluop = ((if_instr[6:0] == op_reg) && if_instr[30]) ? alu_sub : alu_add;
          3'b001: dec.aluop = alu_sll;
          3'b010: begin
            dec.cmpop      = blt;
            dec.regfilemux = rf_br_en;
          end
          3'b011: begin
            dec.cmpop      = bltu;
            dec.regfilemux = rf_br_en;
          end
          3'b100: dec.aluop = alu_xor;
          3'b101: dec.aluop = if_instr[30] ? alu_sra : alu_srl;
          3'b110: dec.aluop = alu_or;
          default: dec.aluop = alu_and;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign haz = EN_HAZARD && if_valid && ex_valid && ex_ctrl_q.read && (ex_ctrl_q.rd != 5'd0) &&
               ((uses_rs1 && (if_instr[19:15] == ex_ctrl_q.rd)) ||
                (uses_rs2 && (if_instr[24:20] == ex_ctrl_q.rd)));

  assign id_ready = ~ex_stall & ~haz & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_pc      <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_illegal <= 1'b0;
      bubble_cnt <= '0;
    end else if (flush) begin
      // flushed entries also drop their side-effect enables
      ex_valid               <= 1'b0;
      ex_illegal             <= 1'b0;
      ex_ctrl_q.load_regfile <= 1'b0;
      ex_ctrl_q.read         <= 1'b0;
      ex_ctrl_q.write        <= 1'b0;
    end else if (ex_stall) begin
    end else if (haz) begin
      ex_valid               <= 1'b0;
      ex_ctrl_q.load_regfile <= 1'b0;
      ex_ctrl_q.read         <= 1'b0;
      ex_ctrl_q.write        <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (if_valid) begin
      ex_valid   <= 1'b1;
      ex_ctrl_q  <= dec;
      ex_pc      <= if_pc;
      ex_rs1     <= if_instr[19:15];
      ex_rs2     <= if_instr[24:20];
      ex_illegal <= dec_illegal;
    end else begin
      ex_valid               <= 1'b0;
      ex_ctrl_q.load_regfile <= 1'b0;
      ex_ctrl_q.read         <= 1'b0;
      ex_ctrl_q.write        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed scenarios plus randomized traffic against a reference model.
// Two instances share stimulus: the default counter width and a 2-bit counter for saturation.
module tb_id_decode_stage;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst, if_valid, ex_stall, flush;
  logic [31:0] if_instr, if_pc;

  logic a_ready, a_valid, a_ill, b_ready, b_valid, b_ill;
  logic [$bits(rv32i_control_word)-1:0] a_ctrl, b_ctrl;
  logic [31:0] a_pc, b_pc;
  logic [4:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic [15:0] a_cnt;
  logic [1:0] b_cnt;
  rv32i_control_word actl;
  assign actl = a_ctrl;

  id_decode_stage #(.CNT_W(16), .EN_HAZARD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_stall(ex_stall), .flush(flush), .id_ready(a_ready), .ex_valid(a_valid),
    .ex_ctrl(a_ctrl), .ex_pc(a_pc), .ex_rs1(a_rs1), .ex_rs2(a_rs2),
    .ex_illegal(a_ill), .bubble_cnt(a_cnt));

  id_decode_stage #(.CNT_W(2), .EN_HAZARD(1'b1)) dut_b (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .ex_stall(ex_stall), .flush(flush), .id_ready(b_ready), .ex_valid(b_valid),
    .ex_ctrl(b_ctrl), .ex_pc(b_pc), .ex_rs1(b_rs1), .ex_rs2(b_rs2),
    .ex_illegal(b_ill), .bubble_cnt(b_cnt));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model state
  logic m_valid, m_ill;
  rv32i_control_word m_ctrl;
  logic [31:0] m_pc;
  logic [4:0] m_rs1, m_rs2;
  int m_bubbles;

  function automatic void ref_decode(input logic [31:0] i, output rv32i_control_word c,
                                     output logic ill, output logic u1, output logic u2);
    regfilemux_sel_t load_tab [8] = '{rf_lb, rf_lh, rf_lw, rf_alu_out, rf_lbu, rf_lhu, rf_alu_out, rf_alu_out};
    alu_ops alu_tab [8] = '{alu_add, alu_sll, alu_add, alu_add, alu_xor, alu_srl, alu_or, alu_and};
    logic [2:0] f3;
    f3 = i[14:12];
    c = '0;
    c.opcode = rv32i_opcode'(i[6:0]);
    c.aluop = alu_add; c.cmpop = beq; c.regfilemux = rf_alu_out; c.pcmux = pc_plus4;
    c.rd = i[11:7]; c.u_imm = {i[31:12], 12'h000};
    ill = 1'b0;
    u1 = (i[6:0] inside {op_jalr, op_br, op_load, op_store, op_imm, op_reg});
    u2 = (i[6:0] inside {op_br, op_store, op_reg});
    if (i[6:0] == op_lui) begin c.load_regfile = 1; c.regfilemux = rf_u_imm; end
    else if (i[6:0] == op_auipc) c.load_regfile = 1;
    else if (i[6:0] == op_jal) begin c.load_regfile = 1; c.regfilemux = rf_pc_plus4; c.pcmux = pc_alu_out; end
    else if (i[6:0] == op_jalr) begin c.load_regfile = 1; c.regfilemux = rf_pc_plus4; c.pcmux = pc_alu_mod2; end
    else if (i[6:0] == op_br) c.cmpop = branch_funct3_t'(f3);
    else if (i[6:0] == op_store) c.write = 1;
    else if (i[6:0] == op_load) begin
      if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin
        c.read = 1; c.load_regfile = 1; c.regfilemux = load_tab[f3];
      end else ill = 1'b1;
    end else if (i[6:0] == op_imm || i[6:0] == op_reg) begin
      c.load_regfile = 1;
      c.aluop = alu_tab[f3];
      if (f3 == 3'd5 && i[30]) c.aluop = alu_sra;
      if (f3 == 3'd0 && i[30] && i[6:0] == op_reg) c.aluop = alu_sub;
      if (f3 == 3'd2) begin c.cmpop = blt; c.regfilemux = rf_br_en; end
      if (f3 == 3'd3) begin c.cmpop = bltu; c.regfilemux = rf_br_en; end
    end else ill = 1'b1;
  endfunction

  function automatic logic model_haz();
    rv32i_control_word c;
    logic ill, u1, u2;
    ref_decode(if_instr, c, ill, u1, u2);
    return if_valid && m_valid && m_ctrl.read && (m_ctrl.rd != 0) &&
           ((u1 && if_instr[19:15] == m_ctrl.rd) || (u2 && if_instr[24:20] == m_ctrl.rd));
  endfunction

  function automatic logic [$bits(rv32i_control_word)+44-1:0] model_state();
    return {m_valid, m_ctrl, m_pc, m_rs1, m_rs2, m_ill};
  endfunction

  task automatic tick();
    rv32i_control_word c;
    logic ill, u1, u2, haz;
    ref_decode(if_instr, c, ill, u1, u2);
    haz = model_haz();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_ctrl = '0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_ill = 0; m_bubbles = 0;
    end else if (flush) begin
      m_valid = 0; m_ill = 0; m_ctrl.load_regfile = 0; m_ctrl.read = 0; m_ctrl.write = 0;
    end else if (ex_stall) begin
    end else if (haz) begin
      m_valid = 0; m_ctrl.load_regfile = 0; m_ctrl.read = 0; m_ctrl.write = 0;
      m_bubbles++;
    end else if (if_valid) begin
      m_valid = 1; m_ctrl = c; m_pc = if_pc; m_rs1 = if_instr[19:15]; m_rs2 = if_instr[24:20]; m_ill = ill;
    end else begin
      m_valid = 0; m_ctrl.load_regfile = 0; m_ctrl.read = 0; m_ctrl.write = 0;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v; if_instr = instr; if_pc = pc;
  endtask

  task automatic test_reset();
    rst = 1; ex_stall = 0; flush = 0; drive(0, 32'h0, 32'h0);
    tick(); tick();
    rst = 0;
    #1;
    total++;
    if ({a_valid, a_ctrl, a_pc, a_rs1, a_rs2, a_ill, a_cnt, b_cnt} !== '0) begin
      bad++; $display("FAIL reset_state: got valid=%b ctrl=%h pc=%h cnt=%0d", a_valid, a_ctrl, a_pc, a_cnt);
    end
    total++;
    if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", a_ready); end
  endtask

  task automatic test_addi();
    drive(1, 32'h00510093, 32'h100);
    tick();
    total++;
    if (a_valid !== 1 || actl.opcode !== op_imm || actl.aluop !== alu_add || actl.rd !== 5'd1 ||
        actl.load_regfile !== 1 || a_rs1 !== 5'd2 || a_pc !== 32'h100) begin
      bad++; $display("FAIL addi_decode: valid=%b op=%h alu=%0d rd=%0d ld=%b rs1=%0d pc=%h",
                      a_valid, actl.opcode, actl.aluop, actl.rd, actl.load_regfile, a_rs1, a_pc);
    end
  endtask

  task automatic test_load_use();
    drive(1, 32'h0000A183, 32'h104);
    tick();
    drive(1, 32'h00518233, 32'h108);
    #1;
    total++;
    if (a_ready !== 1'b0) begin bad++; $display("FAIL load_use_ready: got %b want 0", a_ready); end
    tick();
    total++;
    if (a_valid !== 0 || a_cnt !== 16'd1 || b_cnt !== 2'd1 || actl.read !== 0) begin
      bad++; $display("FAIL load_use_bubble: valid=%b cnt=%0d cnt2=%0d read=%b want 0/1/1/0", a_valid, a_cnt, b_cnt, actl.read);
    end
    total++;
    if (a_ready !== 1'b1) begin bad++; $display("FAIL load_use_clear: ready=%b want 1", a_ready); end
    tick();
    total++;
    if (a_valid !== 1 || actl.aluop !== alu_add || a_pc !== 32'h108 || actl.rd !== 5'd4) begin
      bad++; $display("FAIL load_use_enter: valid=%b alu=%0d pc=%h rd=%0d", a_valid, actl.aluop, a_pc, actl.rd);
    end
  endtask

  task automatic test_alu_variants();
    drive(1, 32'h40838333, 32'h10C);
    tick();
    total++;
    if (actl.aluop !== alu_sub) begin bad++; $display("FAIL sub_aluop: got %0d want %0d", actl.aluop, alu_sub); end
    drive(1, 32'h4030D093, 32'h110);
    tick();
    total++;
    if (actl.aluop !== alu_sra) begin bad++; $display("FAIL srai_aluop: got %0d want %0d", actl.aluop, alu_sra); end
    drive(1, 32'h123452B7, 32'h114);
    tick();
    total++;
    if (actl.u_imm !== 32'h12345000 || actl.regfilemux !== rf_u_imm || actl.rd !== 5'd5) begin
      bad++; $display("FAIL lui_decode: u_imm=%h mux=%0d rd=%0d", actl.u_imm, actl.regfilemux, actl.rd);
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 32'h00510093, 32'h118);
    ex_stall = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (a_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0", k, a_ready); end
      tick();
      total++;
      if (a_valid !== 1 || a_pc !== 32'h114 || actl.u_imm !== 32'h12345000 || actl.opcode !== op_lui) begin
        bad++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h u_imm=%h", k, a_valid, a_pc, actl.u_imm);
      end
    end
    flush = 1;
    tick();
    total++;
    if (a_valid !== 1'b0 || actl.load_regfile !== 1'b0) begin
      bad++; $display("FAIL flush_over_stall: valid=%b ld=%b want 0/0", a_valid, actl.load_regfile);
    end
    flush = 0; ex_stall = 0;
  endtask

  task automatic test_illegal();
    drive(1, 32'h00000073, 32'h11C);
    tick();
    total++;
    if (a_ill !== 1 || a_valid !== 1 || actl.load_regfile !== 0 || actl.read !== 0 || actl.write !== 0) begin
      bad++; $display("FAIL csr_illegal: ill=%b valid=%b ld=%b rd=%b wr=%b", a_ill, a_valid,
                      actl.load_regfile, actl.read, actl.write);
    end
  endtask

  task automatic test_saturation();
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h0000A183, 32'h200 + 12 * k);
      tick();
      drive(1, 32'h00518233, 32'h204 + 12 * k);
      tick();
      tick();
    end
    total++;
    if (b_cnt !== 2'd3) begin bad++; $display("FAIL cnt_saturate: got %0d want 3", b_cnt); end
    total++;
    if (a_cnt !== 16'd4) begin bad++; $display("FAIL cnt_wide: got %0d want 4", a_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    drive(1, 32'h0000A183, 32'h300);
    tick();
    drive(1, 32'h00518233, 32'h304);
    ex_stall = 1;
    tick();
    rst = 1;
    tick();
    total++;
    if ({a_valid, a_ctrl, a_pc, a_rs1, a_rs2, a_ill, a_cnt, b_valid, b_cnt} !== '0) begin
      bad++; $display("FAIL reset_mid_stall: valid=%b ctrl=%h pc=%h cnt=%0d", a_valid, a_ctrl, a_pc, a_cnt);
    end
    rst = 0; ex_stall = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic b30;
    logic [19:0] imm;
    rd = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom_range(0, 7)); b30 = 1'($urandom_range(0, 1)); imm = 20'($urandom);
    case ($urandom_range(0, 10))
      0: return {imm, rd, 7'b0110111};
      1: return {imm, rd, 7'b0010111};
      2: return {imm, rd, 7'b1101111};
      3: return {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4: return {7'b0, rs2, rs1, f3, 5'b0, 7'b1100011};
      5: return {12'h0, rs1, f3, rd, 7'b0000011};
      6: return {7'b0, rs2, rs1, 3'b010, 5'b0, 7'b0100011};
      7: return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0010011};
      8: return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      9: return $urandom;
      default: return {12'h0, rs1, 3'b010, rd, 7'b0000011};
    endcase
  endfunction

  task automatic test_random();
    logic exp_ready;
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 9) < 8), rand_instr(), $urandom);
      ex_stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      exp_ready = !ex_stall && !flush && !model_haz();
      total++;
      if (a_ready !== exp_ready || b_ready !== exp_ready) begin
        bad++; $display("FAIL rand_ready[%0d]: got %b/%b want %b", n, a_ready, b_ready, exp_ready);
      end
      tick();
      total++;
      if ({a_valid, a_ctrl, a_pc, a_rs1, a_rs2, a_ill} !== model_state() ||
          a_cnt !== 16'((m_bubbles > 65535) ? 65535 : m_bubbles)) begin
        bad++; $display("FAIL rand_state_a[%0d]: got %h cnt=%0d want %h cnt=%0d", n,
                        {a_valid, a_ctrl, a_pc, a_rs1, a_rs2, a_ill}, a_cnt, model_state(), m_bubbles);
      end
      total++;
      if ({b_valid, b_ctrl, b_pc, b_rs1, b_rs2, b_ill} !== model_state() ||
          b_cnt !== 2'((m_bubbles > 3) ? 3 : m_bubbles)) begin
        bad++; $display("FAIL rand_state_b[%0d]: got %h cnt=%0d want %h bubbles=%0d", n,
                        {b_valid, b_ctrl, b_pc, b_rs1, b_rs2, b_ill}, b_cnt, model_state(), m_bubbles);
      end
    end
    rst = 0; ex_stall = 0; flush = 0;
  endtask

  initial begin
    m_valid = 0; m_ctrl = '0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_ill = 0; m_bubbles = 0;
    test_reset();
    test_addi();
    test_load_use();
    test_alu_variants();
    test_stall_flush();
    test_illegal();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
